// File: rtl/msrv32_trap_pkg.sv
// Shared cause codes, PC-select encodings and FSM state type for the msrv32
// machine-mode trap controller.
package msrv32_trap_pkg;

  localparam int unsigned CAUSE_MISALIGNED_INSTR = 0;
  localparam int unsigned CAUSE_ILLEGAL_INSTR    = 2;
  localparam int unsigned CAUSE_BREAKPOINT       = 3;
  localparam int unsigned CAUSE_MISALIGNED_LOAD  = 4;
  localparam int unsigned CAUSE_MISALIGNED_STORE = 6;
  localparam int unsigned CAUSE_ECALL_M          = 11;
  localparam int unsigned CAUSE_MSI              = 3;
  localparam int unsigned CAUSE_MTI              = 7;
  localparam int unsigned CAUSE_MEI              = 11;
  localparam int unsigned CAUSE_LOCAL_BASE       = 16;

  localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
  localparam logic [1:0] PC_SRC_EPC  = 2'b01;
  localparam logic [1:0] PC_SRC_TVEC = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRAP = 2'd1,
    ST_MRET = 2'd2,
    ST_WFI  = 2'd3
  } trap_state_e;

  // Exception causes that also load mtval with the faulting address.
  function automatic logic is_misaligned_cause(input int unsigned cause);
    return (cause == CAUSE_MISALIGNED_INSTR) ||
           (cause == CAUSE_MISALIGNED_LOAD)  ||
           (cause == CAUSE_MISALIGNED_STORE);
  endfunction

endpackage

// File: rtl/msrv32_irq_prio_enc.sv
// Combinational interrupt priority encoder: MEI > MSI > MTI > local[0] > ... > local[N-1].
// any_wake ignores the global enable so WFI can wake with interrupts masked.
module msrv32_irq_prio_enc
  import msrv32_trap_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter int CAUSE_W       = 5,
  localparam int LI_W = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
  input  logic               i_mie,
  input  logic               i_meie,
  input  logic               i_meip,
  input  logic               i_msie,
  input  logic               i_msip,
  input  logic               i_mtie,
  input  logic               i_mtip,
  input  logic [LI_W-1:0]    i_lie,
  input  logic [LI_W-1:0]    i_lip,
  output logic               o_any_irq,
  output logic               o_any_wake,
  output logic [CAUSE_W-1:0] o_cause
);

  logic            w_mei;
  logic            w_msi;
  logic            w_mti;
  logic [LI_W-1:0] w_local_hit;

  assign w_mei = i_meie & i_meip;
  assign w_msi = i_msie & i_msip;
  assign w_mti = i_mtie & i_mtip;

  generate
    if (NUM_LOCAL_IRQ > 0) begin : g_local
      assign w_local_hit = i_lie & i_lip;
    end else begin : g_no_local
      assign w_local_hit = '0;
    end
  endgenerate

  assign o_any_wake = w_mei | w_msi | w_mti | (|w_local_hit);
  assign o_any_irq  = i_mie & o_any_wake;

  // Later assignments win, so walk from lowest to highest priority.
  always_comb begin
    o_cause = '0;
    for (int i = LI_W - 1; i >= 0; i--) begin
      if (w_local_hit[i]) o_cause = CAUSE_W'(CAUSE_LOCAL_BASE + 32'(i));
    end
    if (w_mti) o_cause = CAUSE_W'(CAUSE_MTI);
    if (w_msi) o_cause = CAUSE_W'(CAUSE_MSI);
    if (w_mei) o_cause = CAUSE_W'(CAUSE_MEI);
  end

endmodule

// File: rtl/msrv32_trap_controller.sv
// Machine-mode trap sequencer: interrupt/exception entry, mret return and WFI stall/wake.
// state | meaning: RUN normal retire | TRAP one-cycle trap entry | MRET one-cycle return | WFI stalled
module msrv32_trap_controller
  import msrv32_trap_pkg::*;
#(
  parameter int NUM_LOCAL_IRQ = 4,
  parameter int CAUSE_W       = 5,
  localparam int LI_W = (NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1
) (
  input  logic               ms_riscv32_mp_clk_in,
  input  logic               ms_riscv32_mp_rst_in,
  input  logic               instr_valid_in,
  input  logic               misaligned_instr_in,
  input  logic               illegal_instr_in,
  input  logic               misaligned_load_in,
  input  logic               misaligned_store_in,
  input  logic               ecall_in,
  input  logic               ebreak_in,
  input  logic               mret_in,
  input  logic               wfi_in,
  input  logic               mie_in,
  input  logic               meie_in,
  input  logic               mtie_in,
  input  logic               msie_in,
  input  logic               meip_in,
  input  logic               mtip_in,
  input  logic               msip_in,
  input  logic [LI_W-1:0]    lie_in,
  input  logic [LI_W-1:0]    lip_in,
  output logic               trap_taken_out,
  output logic               i_or_e_out,
  output logic               set_epc_out,
  output logic               set_cause_out,
  output logic [CAUSE_W-1:0] cause_out,
  output logic               misaligned_exception_out,
  output logic               mie_clear_out,
  output logic               mie_set_out,
  output logic               instret_inc_out,
  output logic               flush_out,
  output logic               stall_out,
  output logic [1:0]         pc_src_out
);

  trap_state_e        r_state;
  logic               w_irq;
  logic               w_wake;
  logic [CAUSE_W-1:0] w_irq_cause;
  logic               w_exc;
  logic [CAUSE_W-1:0] w_exc_cause;
  logic               w_exc_mis;
  logic               w_mret;
  logic               w_wfi;
  logic               w_take_trap;
  logic [CAUSE_W-1:0] w_trap_cause;

  msrv32_irq_prio_enc #(
    .NUM_LOCAL_IRQ (NUM_LOCAL_IRQ),
    .CAUSE_W       (CAUSE_W)
  ) u_prio_enc (
    .i_mie      (mie_in),
    .i_meie     (meie_in),
    .i_meip     (meip_in),
    .i_msie     (msie_in),
    .i_msip     (msip_in),
    .i_mtie     (mtie_in),
    .i_mtip     (mtip_in),
    .i_lie      (lie_in),
    .i_lip      (lip_in),
    .o_any_irq  (w_irq),
    .o_any_wake (w_wake),
    .o_cause    (w_irq_cause)
  );

  assign w_exc = instr_valid_in & (misaligned_instr_in | illegal_instr_in | ebreak_in |
                                   ecall_in | misaligned_load_in | misaligned_store_in);
  assign w_mret = instr_valid_in & mret_in;
  assign w_wfi  = instr_valid_in & wfi_in;

  always_comb begin
    w_exc_cause = '0;
    if (misaligned_instr_in)      w_exc_cause = CAUSE_W'(CAUSE_MISALIGNED_INSTR);
    else if (illegal_instr_in)    w_exc_cause = CAUSE_W'(CAUSE_ILLEGAL_INSTR);
    else if (ebreak_in)           w_exc_cause = CAUSE_W'(CAUSE_BREAKPOINT);
    else if (ecall_in)            w_exc_cause = CAUSE_W'(CAUSE_ECALL_M);
    else if (misaligned_load_in)  w_exc_cause = CAUSE_W'(CAUSE_MISALIGNED_LOAD);
    else if (misaligned_store_in) w_exc_cause = CAUSE_W'(CAUSE_MISALIGNED_STORE);
  end

  assign w_exc_mis = is_misaligned_cause(32'(w_exc_cause));

  // From WFI only an interrupt can trap; there is no instruction to fault.
  assign w_take_trap  = ((r_state == ST_RUN) && (w_irq || w_exc)) ||
                        ((r_state == ST_WFI) && w_irq);
  assign w_trap_cause = w_irq ? w_irq_cause : w_exc_cause;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state                  <= ST_RUN;
      trap_taken_out           <= 1'b0;
      i_or_e_out               <= 1'b0;
      set_epc_out              <= 1'b0;
      set_cause_out            <= 1'b0;
      cause_out                <= '0;
      misaligned_exception_out <= 1'b0;
      mie_clear_out            <= 1'b0;
      mie_set_out              <= 1'b0;
      instret_inc_out          <= 1'b0;
      flush_out                <= 1'b0;
      stall_out                <= 1'b0;
      pc_src_out               <= PC_SRC_SEQ;
    end else begin
      trap_taken_out           <= w_take_trap;
      i_or_e_out               <= w_take_trap & w_irq;
      set_epc_out              <= w_take_trap;
      set_cause_out            <= w_take_trap;
      misaligned_exception_out <= w_take_trap & ~w_irq & w_exc_mis;
      mie_clear_out            <= w_take_trap;
      mie_set_out              <= 1'b0;
      instret_inc_out          <= 1'b0;
      flush_out                <= w_take_trap;
      stall_out                <= 1'b0;
      pc_src_out               <= w_take_trap ? PC_SRC_TVEC : PC_SRC_SEQ;
      if (w_take_trap) cause_out <= w_trap_cause;

      case (r_state)
        ST_RUN: begin
          if (w_take_trap) begin
            r_state <= ST_TRAP;
          end else if (w_mret) begin
            r_state         <= ST_MRET;
            mie_set_out     <= 1'b1;
            flush_out       <= 1'b1;
            pc_src_out      <= PC_SRC_EPC;
            instret_inc_out <= 1'b1;
          end else if (w_wfi) begin
            r_state   <= ST_WFI;
            stall_out <= 1'b1;
          end else begin
            instret_inc_out <= instr_valid_in;
          end
        end
        ST_WFI: begin
          if (w_wake) begin
            instret_inc_out <= 1'b1;
            r_state         <= w_irq ? ST_TRAP : ST_RUN;
          end else begin
            stall_out <= 1'b1;
          end
        end
        ST_TRAP, ST_MRET: r_state <= ST_RUN;
        default:          r_state <= ST_RUN;
      endcase
    end
  end

endmodule
